mem_access_unit: RTL

- MEM-stage data-memory access unit: the store/request side of the load/store path.
- Takes a load or store from EX and aligns the store data into byte lanes.
- Generates the byte masks (rmask/wmask), drives the data-cache request handshake, and captures the returned word into mdrreg_out for WB.
- WB later extracts and sign-extends loaded bytes using mdrreg_out and rmask; this block never does extension.

---
 rtl/mem_access_unit.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/mem_access_unit.sv
// MEM-stage load/store request unit: lane-aligns store data, builds byte masks, runs the dcache handshake.
// Latency: request sampled in IDLE, dcache request next cycle, done the cycle after data_resp; misaligned = 1 cycle.
module mem_access_unit #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_load,
    input  logic              req_store,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] store_data,
    input  logic              advance,
    output logic              data_read,
    output logic              data_write,
    output logic [3:0]        data_mbe,
    output logic [ADDR_W-1:0] data_addr,
    output logic [DATA_W-1:0] data_wdata,
    input  logic              data_resp,
    input  logic [DATA_W-1:0] data_rdata,
    output logic [DATA_W-1:0] mdrreg_out,
    output logic [3:0]        rmask,
    output logic [3:0]        wmask,
    output logic              misaligned,
    output logic              done,
    output logic              mem_stall
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_e;

    state_e            state_q, state_d;
    logic              data_read_q, data_read_d;
    logic              data_write_q, data_write_d;
    logic [3:0]        data_mbe_q, data_mbe_d;
    logic [ADDR_W-1:0] data_addr_q, data_addr_d;
    logic [DATA_W-1:0] data_wdata_q, data_wdata_d;
    logic [DATA_W-1:0] mdrreg_q, mdrreg_d;
    logic [3:0]        rmask_q, rmask_d;
    logic [3:0]        wmask_q, wmask_d;
    logic              misaligned_q, misaligned_d;
    logic              done_q, done_d;
    logic              is_load_q, is_load_d;

    logic              legal_c;
    logic [1:0]        size_c;
    logic [1:0]        off_c;
    logic [3:0]        mask_c;
    logic [DATA_W-1:0] wdata_c;
    logic              mis_c;

    // Access size decode; anything outside the RV32I load/store funct3 set falls back to a word access.
    always_comb begin
        legal_c = 1'b0;
        if (req_load) begin
            case (funct3)
                3'b000, 3'b001, 3'b010, 3'b100, 3'b101: legal_c = 1'b1;
                default:                                legal_c = 1'b0;
            endcase
        end else begin
            case (funct3)
                3'b000, 3'b001, 3'b010: legal_c = 1'b1;
                default:                legal_c = 1'b0;
            endcase
        end
        size_c = legal_c ? funct3[1:0] : 2'b10;
    end

    always_comb begin
        off_c   = addr[1:0];
        mask_c  = 4'b1111;
        wdata_c = store_data;
        mis_c   = 1'b0;
        case (size_c)
            2'b00: begin
                mask_c  = 4'b0001 << off_c;
                wdata_c = {4{store_data[7:0]}};
            end
            2'b01: begin
                mask_c  = 4'b0011 << off_c;
                wdata_c = {2{store_data[15:0]}};
                mis_c   = off_c[0];
            end
            default: begin
                mask_c  = 4'b1111;
                wdata_c = store_data;
                mis_c   = (off_c != 2'b00);
            end
        endcase
    end

    always_comb begin
        state_d      = state_q;
        data_read_d  = data_read_q;
        data_write_d = data_write_q;
        data_mbe_d   = data_mbe_q;
        data_addr_d  = data_addr_q;
        data_wdata_d = data_wdata_q;
        mdrreg_d     = mdrreg_q;
        rmask_d      = rmask_q;
        wmask_d      = wmask_q;
        misaligned_d = misaligned_q;
        done_d       = done_q;
        is_load_d    = is_load_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (mis_c) begin
                        state_d      = DONE;
                        misaligned_d = 1'b1;
                        done_d       = 1'b1;
                        rmask_d      = 4'b0000;
                        wmask_d      = 4'b0000;
                    end else begin
                        state_d      = BUSY;
                        is_load_d    = req_load;
                        // Load wins if both are ever set, so read and write can never be raised together.
                        data_read_d  = req_load;
                        data_write_d = req_store && !req_load;
                        data_addr_d  = {addr[ADDR_W-1:2], 2'b00};
                        data_mbe_d   = mask_c;
                        data_wdata_d = wdata_c;
                        rmask_d      = req_load ? mask_c : 4'b0000;
                        wmask_d      = req_load ? 4'b0000 : mask_c;
                    end
                end
            end
            BUSY: begin
                if (data_resp) begin
                    state_d      = DONE;
                    data_read_d  = 1'b0;
                    data_write_d = 1'b0;
                    done_d       = 1'b1;
                    if (is_load_q) begin
                        mdrreg_d = data_rdata;
                    end
                end
            end
            DONE: begin
                if (advance) begin
                    state_d      = IDLE;
                    done_d       = 1'b0;
                    misaligned_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            data_read_q  <= 1'b0;
            data_write_q <= 1'b0;
            data_mbe_q   <= 4'b0000;
            data_addr_q  <= '0;
            data_wdata_q <= '0;
            mdrreg_q     <= '0;
            rmask_q      <= 4'b0000;
            wmask_q      <= 4'b0000;
            misaligned_q <= 1'b0;
            done_q       <= 1'b0;
            is_load_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            data_read_q  <= data_read_d;
            data_write_q <= data_write_d;
            data_mbe_q   <= data_mbe_d;
            data_addr_q  <= data_addr_d;
            data_wdata_q <= data_wdata_d;
            mdrreg_q     <= mdrreg_d;
            rmask_q      <= rmask_d;
            wmask_q      <= wmask_d;
            misaligned_q <= misaligned_d;
            done_q       <= done_d;
            is_load_q    <= is_load_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && req_valid && state_q == IDLE) begin
            assert (legal_c)
            else $fatal(1, "mem_access_unit: illegal funct3 %b", funct3);
        end
    end

    assign data_read  = data_read_q;
    assign data_write = data_write_q;
    assign data_mbe   = data_mbe_q;
    assign data_addr  = data_addr_q;
    assign data_wdata = data_wdata_q;
    assign mdrreg_out = mdrreg_q;
    assign rmask      = rmask_q;
    assign wmask      = wmask_q;
    assign misaligned = misaligned_q;
    assign done       = done_q;
    assign mem_stall  = req_valid && (state_q != DONE);

endmodule
